// File: rtl/bank_ch_credit_return.sv
// Per-channel read buffer that turns each read popped toward memory into one credit pulse for the issue side.
// Optional sticky overflow detection is built when BANK_CH_CREDIT_OVERFLOW_CHECK_EN is defined.
module bank_ch_credit_return #(
    parameter int CREDIT_NUM = 8,
    parameter int PTR_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            isu_rd_valid,
    input  logic [PTR_WIDTH-1:0]            isu_rd_tag,
    output logic                            mem_rd_valid,
    output logic [PTR_WIDTH-1:0]            mem_rd_tag,
    input  logic                            mem_rd_ready,
    output logic                            credit_release,
    output logic [$clog2(CREDIT_NUM):0]     occupancy,
    output logic                            err_overflow
);

    localparam int AW = (CREDIT_NUM > 1) ? $clog2(CREDIT_NUM) : 1;
    localparam int OW = $clog2(CREDIT_NUM) + 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(CREDIT_NUM - 1);
    localparam logic [OW-1:0] FULL_CNT = OW'(CREDIT_NUM);

    logic [PTR_WIDTH-1:0] buf_q [CREDIT_NUM];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [OW-1:0]        occ_q;
    logic                 rel_q;
    logic                 full;
    logic                 pop;
    logic                 push;

    // Handshake: the memory side transfers the head in any cycle where
    // mem_rd_valid and mem_rd_ready are both high; the head is held while
    // valid is high and ready is low. The issue side has no ready: a push
    // is legal only while it holds a credit.
    assign full = (occ_q == FULL_CNT);
    assign pop  = (occ_q != '0) & mem_rd_ready;
    // At full, a same-cycle pop frees the slot the push is about to fill.
    assign push = isu_rd_valid & (~full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
            rel_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
            rel_q <= pop;
        end
    end

    // Tag storage carries no reset; only the pointers define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_q[wr_ptr] <= isu_rd_tag;
        end
    end

    assign mem_rd_valid   = (occ_q != '0);
    assign mem_rd_tag     = buf_q[rd_ptr];
    assign credit_release = rel_q;
    assign occupancy      = occ_q;

`ifdef BANK_CH_CREDIT_OVERFLOW_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (isu_rd_valid & full & ~pop) begin
            err_q <= 1'b1;
        end
    end

    assign err_overflow = err_q;
`else
    assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_bank_ch_credit_return.sv
// Directed and randomized bench for bank_ch_credit_return: a reference queue of expected tags
// is filled on accepted pushes and drained on memory-side handshakes.
module tb_bank_ch_credit_return;

    localparam int CN = 8;
    localparam int PW = 8;

    logic          clk;
    logic          rst_n;
    logic          isu_rd_valid;
    logic [PW-1:0] isu_rd_tag;
    logic          mem_rd_valid;
    logic [PW-1:0] mem_rd_tag;
    logic          mem_rd_ready;
    logic          credit_release;
    logic [3:0]    occupancy;
    logic          err_overflow;

    bank_ch_credit_return #(.CREDIT_NUM(CN), .PTR_WIDTH(PW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .isu_rd_valid   (isu_rd_valid),
        .isu_rd_tag     (isu_rd_tag),
        .mem_rd_valid   (mem_rd_valid),
        .mem_rd_tag     (mem_rd_tag),
        .mem_rd_ready   (mem_rd_ready),
        .credit_release (credit_release),
        .occupancy      (occupancy),
        .err_overflow   (err_overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BANK_CH_CREDIT_OVERFLOW_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    // scoreboard
    logic [PW-1:0] exp_q[$];
    int   model_occ;
    logic model_rel;
    logic model_err;
    int   vectors;
    int   miscompares;
    int   rel_seen;
    int   max_occ;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver: apply inputs for one clock, compare at the falling edge, advance the model
    task automatic cycle(input logic v, input logic [PW-1:0] t, input logic r, input logic rn);
        logic pop;
        logic acc;
        isu_rd_valid = v;
        isu_rd_tag   = t;
        mem_rd_ready = r;
        rst_n        = rn;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            model_occ = 0;
            model_rel = 1'b0;
            model_err = 1'b0;
        end
        check("mem_rd_valid", {31'd0, mem_rd_valid}, {31'd0, model_occ != 0});
        check("occupancy", {28'd0, occupancy}, model_occ);
        check("credit_release", {31'd0, credit_release}, {31'd0, model_rel});
        check("err_overflow", {31'd0, err_overflow}, {31'd0, model_err});
        if (model_occ != 0) check("mem_rd_tag", {24'd0, mem_rd_tag}, {24'd0, exp_q[0]});
        if (credit_release === 1'b1) rel_seen++;
        if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        if (rst_n) begin
            pop = (model_occ != 0) && r;
            acc = v && ((model_occ < CN) || pop);
            if (v && model_occ == CN && !pop && ERR_EN) model_err = 1'b1;
            if (pop) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(t);
            model_occ = model_occ + int'(acc) - int'(pop);
            model_rel = pop;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (model_occ != 0 && n < budget) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b1);
            n++;
        end
        check("drain_done", model_occ, 0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    initial begin
        int pushed;
        int guard;
        vectors     = 0;
        miscompares = 0;
        rel_seen    = 0;
        max_occ     = 0;
        model_occ   = 0;
        model_rel   = 1'b0;
        model_err   = 1'b0;
        isu_rd_valid = 1'b0;
        isu_rd_tag   = '0;
        mem_rd_ready = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("reset_occupancy", {28'd0, occupancy}, 0);
        check("reset_release", {31'd0, credit_release}, 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);

        // three pushes held back by ready low
        rel_seen = 0;
        cycle(1'b1, 8'h10, 1'b0, 1'b1);
        cycle(1'b1, 8'h11, 1'b0, 1'b1);
        cycle(1'b1, 8'h12, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("three_push_occ", {28'd0, occupancy}, 3);
        check("three_push_head", {24'd0, mem_rd_tag}, 32'h10);
        check("three_push_no_credit", rel_seen, 0);

        // release them in order
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("three_pop_credits", rel_seen, 3);
        check("three_pop_occ", {28'd0, occupancy}, 0);

        // full buffer, simultaneous push and pop
        for (int i = 0; i < CN; i++) cycle(1'b1, 8'h20 + 8'(i), 1'b0, 1'b1);
        rel_seen = 0;
        cycle(1'b1, 8'h55, 1'b1, 1'b1);
        check("full_pushpop_occ", {28'd0, occupancy}, CN);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("full_pushpop_one_credit", rel_seen, 1);
        drain(20);

        // credit violation at full
        for (int i = 0; i < CN; i++) cycle(1'b1, 8'h40 + 8'(i), 1'b0, 1'b1);
        cycle(1'b1, 8'h99, 1'b0, 1'b1);
        check("overflow_occ", {28'd0, occupancy}, CN);
        check("overflow_flag", {31'd0, err_overflow}, {31'd0, ERR_EN});
        drain(20);
        check("overflow_flag_sticky", {31'd0, err_overflow}, {31'd0, ERR_EN});

        // reset while pops are in flight
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        check("async_rst_occ", {28'd0, occupancy}, 0);
        check("async_rst_valid", {31'd0, mem_rd_valid}, 0);
        check("async_rst_release", {31'd0, credit_release}, 0);
        check("async_rst_err", {31'd0, err_overflow}, 0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        rel_seen = 0;
        for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1);
        check("post_rst_no_credit", rel_seen, 0);

        // random ready with credited pushes across pointer wrap
        pushed   = 0;
        guard    = 0;
        rel_seen = 0;
        max_occ  = 0;
        while (pushed < 20 && guard < 400) begin
            if (model_occ < CN && $urandom_range(0, 3) != 0) begin
                cycle(1'b1, 8'h80 + 8'(pushed), 1'($urandom_range(0, 1)), 1'b1);
                pushed++;
            end else begin
                cycle(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b1);
            end
            guard++;
        end
        check("random_all_pushed", pushed, 20);
        drain(100);
        check("random_credits", rel_seen, 20);
        check("random_occ_bound", {31'd0, max_occ <= CN}, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
